// File: rtl/div_core.sv
// ---------------------------------------------------------------------------
// div_core
// Sequential radix-2 restoring divider. Pops one packed operation word
// {signed flag, dividend, divisor} from the upstream FIFO. It produces one
// quotient bit per clock and holds the result on a ready/valid output port
// until the consumer takes it.
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous, active-high reset
//   in_data_i    {signed_op, dividend[WIDTH-1:0], divisor[WIDTH-1:0]}
//   in_valid_i   operation available (FIFO valid)
//   in_ready_o   core can accept an operation (FIFO ready / pop)
//   quot_o       quotient (rounds toward zero)
//   rem_o        remainder (sign follows dividend)
//   dbz_o        divisor was zero
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//
// Parameters
//   WIDTH        operand width
//   CNT_W        iteration counter width, 2**CNT_W must exceed WIDTH
// ---------------------------------------------------------------------------
module div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2*WIDTH:0]   in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o,
  output logic               dbz_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_div;
  logic               r_qNeg;
  logic               r_rNeg;
  logic               r_dbzPend;

  logic [WIDTH-1:0]   r_quotOut;
  logic [WIDTH-1:0]   r_remOut;
  logic               r_dbzOut;

  logic               w_signedOp;
  logic [WIDTH-1:0]   w_dividend;
  logic [WIDTH-1:0]   w_divisor;
  logic               w_dividendNeg;
  logic               w_divisorNeg;
  logic [WIDTH-1:0]   w_absDividend;
  logic [WIDTH-1:0]   w_absDivisor;
  logic               w_divByZero;
  logic               w_accept;

  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_trial;
  logic               w_trialOk;
  logic [WIDTH-1:0]   w_nextRem;
  logic [WIDTH-1:0]   w_nextQuot;
  logic               w_lastIter;

  logic [WIDTH-1:0]   w_quotFixed;
  logic [WIDTH-1:0]   w_remFixed;

  // Unpack the operation word and form operand magnitudes. A negative
  // operand is only treated as negative when the signed flag is set.
  always_comb begin
    w_signedOp    = in_data_i[2*WIDTH];
    w_dividend    = in_data_i[2*WIDTH-1:WIDTH];
    w_divisor     = in_data_i[WIDTH-1:0];
    w_dividendNeg = w_signedOp & w_dividend[WIDTH-1];
    w_divisorNeg  = w_signedOp & w_divisor[WIDTH-1];
    w_absDividend = w_dividendNeg ? (-w_dividend) : w_dividend;
    w_absDivisor  = w_divisorNeg  ? (-w_divisor)  : w_divisor;
    w_divByZero   = (w_divisor == '0);
    w_accept      = in_valid_i & in_ready_o;
  end

  // One restoring iteration: shift {rem,quot} left, try subtracting the
  // divisor magnitude one bit wider than the operands so the borrow out
  // is the sign of the trial. The shifted remainder is always below twice
  // the divisor, so WIDTH+1 bits never overflow.
  always_comb begin
    w_remShift = {r_rem, r_quot[WIDTH-1]};
    w_trial    = w_remShift - {1'b0, r_div};
    w_trialOk  = ~w_trial[WIDTH];
    w_nextRem  = w_trialOk ? w_trial[WIDTH-1:0] : w_remShift[WIDTH-1:0];
    w_nextQuot = {r_quot[WIDTH-2:0], w_trialOk};
    w_lastIter = (r_cnt == CNT_W'(1));
  end

  // Apply result signs. For most-negative / -1 the magnitude quotient is
  // 2**(WIDTH-1) with q_neg clear, which truncates back to most-negative.
  always_comb begin
    w_quotFixed = r_qNeg ? (-r_quot) : r_quot;
    w_remFixed  = r_rNeg ? (-r_rem)  : r_rem;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. Accepting is only possible in IDLE
  // and never while reset is asserted, so the FIFO cannot pop an entry
  // that the core would then drop. A divide-by-zero goes through FIX too,
  // which gives it the one-cycle result latency.
  always_comb begin
    w_nextState = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready_o = ~rst_i;
        if (w_accept) begin
          w_nextState = w_divByZero ? FIX : CALC;
        end
      end
      CALC: begin
        if (w_lastIter) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        w_nextState = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. On a divide-by-zero the iteration registers are
  // reused to carry the fixed result (all-ones quotient, raw dividend) to
  // FIX with both sign corrections disabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_qNeg    <= 1'b0;
      r_rNeg    <= 1'b0;
      r_dbzPend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_divByZero) begin
              r_cnt     <= '0;
              r_rem     <= w_dividend;
              r_quot    <= '1;
              r_div     <= '0;
              r_qNeg    <= 1'b0;
              r_rNeg    <= 1'b0;
              r_dbzPend <= 1'b1;
            end else begin
              r_cnt     <= CNT_W'(WIDTH);
              r_rem     <= '0;
              r_quot    <= w_absDividend;
              r_div     <= w_absDivisor;
              r_qNeg    <= w_dividendNeg ^ w_divisorNeg;
              r_rNeg    <= w_dividendNeg;
              r_dbzPend <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem  <= w_nextRem;
          r_quot <= w_nextQuot;
          r_cnt  <= r_cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers, loaded only in FIX so they stay constant for the
  // whole DONE phase regardless of backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_quotOut <= '0;
      r_remOut  <= '0;
      r_dbzOut  <= 1'b0;
    end else if (r_state == FIX) begin
      r_quotOut <= w_quotFixed;
      r_remOut  <= w_remFixed;
      r_dbzOut  <= r_dbzPend;
    end
  end

  assign quot_o = r_quotOut;
  assign rem_o  = r_remOut;
  assign dbz_o  = r_dbzOut;

endmodule

// File: tb/tb_div_core.sv
// ---------------------------------------------------------------------------
// tb_div_core
// Directed bench for div_core. A small array-based FIFO model feeds the
// core; the FIFO read pointer advances only on a real handshake, so the
// element count shows whether the core popped entries it should not have.
// ---------------------------------------------------------------------------
module tb_div_core;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [2*WIDTH:0]   in_data_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [WIDTH-1:0]   quot_o;
  logic [WIDTH-1:0]   rem_o;
  logic               dbz_o;
  logic               out_valid_o;
  logic               out_ready_i = 1'b1;

  logic [2*WIDTH:0]   fifoMem [0:31];
  int                 wrPtr = 0;
  int                 rdPtr = 0;
  int                 cyc = 0;
  int                 acceptCyc = 0;
  int                 passCount = 0;
  int                 failCount = 0;
  int                 checkCount = 0;
  int                 lat;
  int                 validHighs;

  div_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .quot_o      (quot_o),
    .rem_o       (rem_o),
    .dbz_o       (dbz_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  assign in_valid_i = (wrPtr != rdPtr);
  assign in_data_i  = fifoMem[rdPtr[4:0]];

  // FIFO read side and edge counter; acceptCyc holds the edge number of the
  // most recent pop.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (in_valid_i && in_ready_o) begin
      rdPtr     <= rdPtr + 1;
      acceptCyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    fifoMem[wrPtr[4:0]] = {s, a, b};
    wrPtr++;
  endtask

  task automatic waitValid(output int latOut);
    latOut = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        latOut = cyc - acceptCyc;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic s, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expQ,
                       input logic [WIDTH-1:0] expR, input logic expDbz, input int expLat);
    int l;
    applyStimulus(s, a, b);
    waitValid(l);
    checkOutput({tag, " latency"}, 64'(l), 64'(expLat));
    checkOutput({tag, " quot"}, 64'(quot_o), 64'(expQ));
    checkOutput({tag, " rem"}, 64'(rem_o), 64'(expR));
    checkOutput({tag, " dbz"}, 64'(dbz_o), 64'(expDbz));
    @(negedge clk_i);
    checkOutput({tag, " valid drop"}, 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    $display("[TB] start");

    // reset state
    @(negedge clk_i);
    checkOutput("reset in_ready", 64'(in_ready_o), 64'd0);
    @(negedge clk_i);
    checkOutput("reset out_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset quot", 64'(quot_o), 64'd0);
    checkOutput("reset rem", 64'(rem_o), 64'd0);
    checkOutput("reset dbz", 64'(dbz_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle in_ready", 64'(in_ready_o), 64'd1);

    // directed single operations, no backpressure
    runOp("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    runOp("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    runOp("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    runOp("s-9/-4", 1'b1, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    runOp("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    runOp("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    runOp("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
    runOp("uMax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    runOp("u unsigned top", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);

    // backpressure with three queued operations
    out_ready_i = 1'b0;
    applyStimulus(1'b0, 32'd20, 32'd3);
    applyStimulus(1'b0, 32'd50, 32'd7);
    applyStimulus(1'b0, 32'd1000, 32'd10);
    waitValid(lat);
    checkOutput("bp1 latency", 64'(lat), 64'd33);
    checkOutput("bp1 quot", 64'(quot_o), 64'd6);
    checkOutput("bp1 rem", 64'(rem_o), 64'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checkOutput("bp hold valid", 64'(out_valid_o), 64'd1);
      checkOutput("bp hold quot", 64'(quot_o), 64'd6);
      checkOutput("bp hold rem", 64'(rem_o), 64'd2);
      checkOutput("bp hold in_ready", 64'(in_ready_o), 64'd0);
      checkOutput("bp fifo count", 64'(wrPtr - rdPtr), 64'd2);
    end
    out_ready_i = 1'b1;
    waitValid(lat);
    checkOutput("bp2 latency", 64'(lat), 64'd33);
    checkOutput("bp2 quot", 64'(quot_o), 64'd7);
    checkOutput("bp2 rem", 64'(rem_o), 64'd1);
    waitValid(lat);
    checkOutput("bp3 latency", 64'(lat), 64'd33);
    checkOutput("bp3 quot", 64'(quot_o), 64'd100);
    checkOutput("bp3 rem", 64'(rem_o), 64'd0);
    @(negedge clk_i);
    checkOutput("bp drained valid", 64'(out_valid_o), 64'd0);
    checkOutput("bp drained fifo", 64'(wrPtr - rdPtr), 64'd0);

    // reset on the 10th CALC cycle discards the operation
    applyStimulus(1'b0, 32'd1000, 32'd3);
    @(negedge clk_i);
    checkOutput("mid accept edge", 64'(acceptCyc), 64'(cyc));
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("mid reset valid", 64'(out_valid_o), 64'd0);
    checkOutput("mid reset quot", 64'(quot_o), 64'd0);
    checkOutput("mid reset rem", 64'(rem_o), 64'd0);
    checkOutput("mid reset dbz", 64'(dbz_o), 64'd0);
    validHighs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (out_valid_o) validHighs++;
    end
    checkOutput("mid no result pulse", 64'(validHighs), 64'd0);
    checkOutput("mid entry consumed", 64'(wrPtr - rdPtr), 64'd0);
    checkOutput("mid in_ready", 64'(in_ready_o), 64'd1);
    runOp("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
